lsu_mem_stage: RTL and testbench

- Load/store unit between the EX/MEM pipeline boundary and the word-organised data memory (64 x 32-bit, combinational read, word write).
- Accepts byte-addressed RV32I load/store requests and performs word reads.
- Extracts and sign/zero-extends sub-word load data.
- Performs sub-word stores as a two-cycle read-modify-write, so the memory sees only full-word writes.
- Stalls the pipeline through a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_extract_merge.sv | 48 ++++
 rtl/lsu_mem_stage.sv | 120 ++++++++++++
 tb/tb_lsu_mem_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: state codes, RV32I funct3 sizes
// and access-legality helpers.
package lsu_pkg;

  localparam int unsigned WORD_AW = 6;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RD   = 2'd1;
  localparam state_t WR   = 2'd2;
  localparam state_t RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants, so funct3[2] is illegal on a store.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: bad = 1'b0;
      default:                        bad = 1'b1;
    endcase
    return bad | (we & f3[2]);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (f3[1:0] == 2'b01)
      bad = off[0];
    else if (f3[1:0] == 2'b10)
      bad = (off != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_extract_merge.sv
// Combinational lane logic: sub-word load select/extend and sub-word store
// merge into an existing memory word.
module lsu_extract_merge
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  // Halfwords align to offset[1]; offset[0] is ignored here by design.
  always_comb begin
    merged = word;
    case (funct3[1:0])
      2'b00: merged[{offset, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (offset[1])
          merged[31:16] = wdata[15:0];
        else
          merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit in front of a 64x32 word memory; sub-word stores use
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;

  logic              req_bad;
  logic              req_sub_store;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  lsu_extract_merge u_lanes (
    .word      (mem_rdata),
    .wdata     (wdata_q),
    .offset    (addr_q[1:0]),
    .funct3    (f3_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    req_bad = f3_illegal(req_funct3, req_we) | f3_misaligned(req_funct3, req_addr[1:0]);
`else
    req_bad = f3_illegal(req_funct3, req_we);
`endif
    req_sub_store = req_we && (req_funct3 != F3_W);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            f3_q    <= req_funct3;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (req_bad) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else if (!req_we || req_sub_store) begin
              state <= RD;
            end else begin
              state <= WR;
            end
          end
        end
        RD: begin
          if (!we_q) begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else begin
            merge_q <= merged;
            state   <= WR;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes are qualified by rst_n so a reset mid-RMW never writes.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_re     = rst_n && (state == RD);
    mem_we     = rst_n && (state == WR);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state == RD || state == WR)
      mem_addr = addr_q[ADDR_W-1:2];
    if (state == WR)
      mem_wdata = (f3_q == F3_W) ? wdata_q : merge_q;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage with a behavioural 64x32
// combinational-read memory.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_re;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  int unsigned we_cnt = 0;
  int unsigned re_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re)
      re_cnt <= re_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE, measure acceptance-to-resp_valid latency,
  // check response and memory-access counts, then return to IDLE.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata,
                        input logic exp_err, input int unsigned exp_re,
                        input int unsigned exp_we);
    int lat;
    int unsigned re0, we0;
    @(negedge clk);
    re0 = re_cnt;
    we0 = we_cnt;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_err});
    check({tag, ".re_cnt"}, re_cnt - re0, exp_re);
    check({tag, ".we_cnt"}, we_cnt - we0, exp_we);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h00BC614E;
    mem[1] = 32'h00000009;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_err", {31'b0, resp_err}, 32'd0);
    check("rst.mem_we", {31'b0, mem_we}, 32'd0);
    check("rst.mem_re", {31'b0, mem_re}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle.ready", {31'b0, req_ready}, 32'd1);

    do_req("lb02",  1'b0, 3'b000, 8'h02, 32'h0, 2, 32'hFFFFFFBC, 1'b0, 1, 0);
    do_req("lbu02", 1'b0, 3'b100, 8'h02, 32'h0, 2, 32'h000000BC, 1'b0, 1, 0);
    do_req("lh00",  1'b0, 3'b001, 8'h00, 32'h0, 2, 32'h0000614E, 1'b0, 1, 0);
    do_req("lhu02", 1'b0, 3'b101, 8'h02, 32'h0, 2, 32'h000000BC, 1'b0, 1, 0);
    do_req("lw04",  1'b0, 3'b010, 8'h04, 32'h0, 2, 32'h00000009, 1'b0, 1, 0);
    do_req("lb_wrap", 1'b0, 3'b000, 8'h00 + 8'd0, 32'h0, 2, 32'h0000004E, 1'b0, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw02",  1'b0, 3'b010, 8'h02, 32'h0, 1, 32'h00000000, 1'b1, 0, 0);
    do_req("lh01",  1'b0, 3'b001, 8'h01, 32'h0, 1, 32'h00000000, 1'b1, 0, 0);
`else
    do_req("lw02",  1'b0, 3'b010, 8'h02, 32'h0, 2, 32'h00BC614E, 1'b0, 1, 0);
    do_req("lh01",  1'b0, 3'b001, 8'h01, 32'h0, 2, 32'h0000614E, 1'b0, 1, 0);
`endif

    do_req("sb01",  1'b1, 3'b000, 8'h01, 32'h000000AA, 3, 32'h0, 1'b0, 1, 1);
    check("sb01.word0", mem[0], 32'h00BCAA4E);
    do_req("sh06",  1'b1, 3'b001, 8'h06, 32'h0000CAFE, 3, 32'h0, 1'b0, 1, 1);
    check("sh06.word1", mem[1], 32'hCAFE0009);
    do_req("sw00",  1'b1, 3'b010, 8'h00, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
    check("sw00.word0", mem[0], 32'hDEADBEEF);

    do_req("ld011", 1'b0, 3'b011, 8'h00, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    do_req("sbu",   1'b1, 3'b100, 8'h00, 32'h11, 1, 32'h0, 1'b1, 0, 0);
    check("sbu.word0", mem[0], 32'hDEADBEEF);

    // Request held high through the transaction: exactly one acceptance.
    @(negedge clk);
    begin
      int unsigned re0;
      re0 = re_cnt;
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h04; req_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold.rd_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("hold.resp_valid", {31'b0, resp_valid}, 32'd1);
      check("hold.resp_ready", {31'b0, req_ready}, 32'd0);
      check("hold.rdata", resp_rdata, 32'hCAFE0009);
      check("hold.re_cnt", re_cnt - re0, 32'd1);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("hold.idle_ready", {31'b0, req_ready}, 32'd1);
      check("hold.re_after", re_cnt - re0, 32'd1);
    end

    // Reset during the RD cycle of a sub-word store drops the store.
    @(negedge clk);
    begin
      int unsigned we0;
      we0 = we_cnt;
      req_we = 1'b1; req_funct3 = 3'b001; req_addr = 8'h02;
      req_wdata = 32'h00001234; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rmw.rd_re", {31'b0, mem_re}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rmw.re_gated", {31'b0, mem_re}, 32'd0);
      @(posedge clk);
      #1;
      check("rmw.we_in_rst", {31'b0, mem_we}, 32'd0);
      rst_n = 1'b1;
      check("rmw.ready", {31'b0, req_ready}, 32'd1);
      check("rmw.resp_valid", {31'b0, resp_valid}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("rmw.we_cnt", we_cnt - we0, 32'd0);
      check("rmw.word0", mem[0], 32'hDEADBEEF);
    end

    do_req("post_lhu", 1'b0, 3'b101, 8'h02, 32'h0, 2, 32'h0000DEAD, 1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
